// File: rtl/ks_adder_checker.sv
// ks_adder_checker
// Response checker for a pipelined Kogge-Stone adder. Each operand set
// launched into the adder is carried through a valid-tagged delay line that
// is as deep as the adder pipeline. When it reaches the last stage, the golden
// {cout,sum} is recomputed and compared with what the adder returns. Pass/fail
// statistics are kept alongside the comparison.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous, active-high reset
//   in_vld     operand set on A/B/cin is launched into the adder this cycle
//   A, B       adder operands [bw:1]
//   cin        adder carry-in
//   sum, cout  adder result returned LAT cycles after launch
//   err        one-cycle pulse: the registered compare mismatched
//   fail       sticky mismatch flag since reset
//   chk_cnt    saturating number of compares
//   err_cnt    saturating number of mismatches
//   first_exp  expected {cout,sum} of the first mismatch
//   first_got  observed {cout,sum} of the first mismatch
module ks_adder_checker #(
  parameter int bw  = 32,
  parameter int LAT = 3,   // legal range 1..16
  parameter int CW  = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_vld,
  input  logic [bw:1]   A,
  input  logic [bw:1]   B,
  input  logic          cin,
  input  logic [bw:1]   sum,
  input  logic          cout,
  output logic          err,
  output logic          fail,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [bw:0]   first_exp,
  output logic [bw:0]   first_got
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  // delay line: vld is reset, operand data is masked by vld and left unreset
  logic [LAT:1] vld_q;
  logic [bw:1]  a_q   [LAT:1];
  logic [bw:1]  b_q   [LAT:1];
  logic [LAT:1] cin_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_q <= '0;
    end else begin
      vld_q[1] <= in_vld;
      for (int k = 2; k <= LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    a_q[1]   <= A;
    b_q[1]   <= B;
    cin_q[1] <= cin;
    for (int k = 2; k <= LAT; k++) begin
      a_q[k]   <= a_q[k-1];
      b_q[k]   <= b_q[k-1];
      cin_q[k] <= cin_q[k-1];
    end
  end

  // golden result at bw+1 bits; the MSB is the expected carry-out
  logic [bw:0] exp_w;
  logic [bw:0] got_w;
  logic        cmp_w;
  logic        mis_w;

  assign exp_w = {1'b0, a_q[LAT]} + {1'b0, b_q[LAT]} + {{bw{1'b0}}, cin_q[LAT]};
  assign got_w = {cout, sum};
  assign cmp_w = vld_q[LAT];
  assign mis_w = cmp_w && (exp_w != got_w);

  logic          err_q,       err_d;
  logic          fail_q,      fail_d;
  logic [CW-1:0] chk_cnt_q,   chk_cnt_d;
  logic [CW-1:0] err_cnt_q,   err_cnt_d;
  logic [bw:0]   first_exp_q, first_exp_d;
  logic [bw:0]   first_got_q, first_got_d;

  always_comb begin
    err_d       = mis_w;
    fail_d      = fail_q | mis_w;
    chk_cnt_d   = chk_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;

    if (cmp_w && (chk_cnt_q != CNT_MAX)) begin
      chk_cnt_d = chk_cnt_q + CW'(1);
    end
    if (mis_w && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CW'(1);
    end
    // capture only the mismatch that first raises fail
    if (mis_w && !fail_q) begin
      first_exp_d = exp_w;
      first_got_d = got_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q       <= 1'b0;
      fail_q      <= 1'b0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      err_q       <= err_d;
      fail_q      <= fail_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  assign err       = err_q;
  assign fail      = fail_q;
  assign chk_cnt   = chk_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign first_exp = first_exp_q;
  assign first_got = first_got_q;

endmodule

// File: tb/tb_ks_adder_checker.sv
module tb_ks_adder_checker;
  localparam int BW   = 32;
  localparam int LAT  = 3;
  localparam int CW   = 16;
  localparam int CW_S = 4;
  localparam int unsigned MAX_M = (1 << CW) - 1;
  localparam int unsigned MAX_S = (1 << CW_S) - 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          in_vld = 1'b0;
  logic [BW:1]   A = '0;
  logic [BW:1]   B = '0;
  logic          cin = 1'b0;
  logic [BW:1]   sum = '0;
  logic          cout = 1'b0;

  logic          err, fail;
  logic [CW-1:0] chk_cnt, err_cnt;
  logic [BW:0]   first_exp, first_got;

  logic            err_s, fail_s;
  logic [CW_S-1:0] chk_cnt_s, err_cnt_s;
  logic [BW:0]     first_exp_s, first_got_s;

  ks_adder_checker #(.bw(BW), .LAT(LAT), .CW(CW)) u_dut (
    .CLK(CLK), .RESET(RESET), .in_vld(in_vld), .A(A), .B(B), .cin(cin),
    .sum(sum), .cout(cout), .err(err), .fail(fail), .chk_cnt(chk_cnt),
    .err_cnt(err_cnt), .first_exp(first_exp), .first_got(first_got)
  );

  ks_adder_checker #(.bw(BW), .LAT(LAT), .CW(CW_S)) u_sat (
    .CLK(CLK), .RESET(RESET), .in_vld(in_vld), .A(A), .B(B), .cin(cin),
    .sum(sum), .cout(cout), .err(err_s), .fail(fail_s), .chk_cnt(chk_cnt_s),
    .err_cnt(err_cnt_s), .first_exp(first_exp_s), .first_got(first_got_s)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          v;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          c;
    logic [BW:0]   exp;
    logic [BW:0]   got;
  } item_t;

  // adder model: launches still in flight inside the adder
  item_t hist[$];

  // reference model of the checker outputs
  int unsigned mdl_chk, mdl_errc, mdl_chk_s, mdl_errc_s;
  logic        mdl_err, mdl_fail;
  logic [BW:0] mdl_fexp, mdl_fgot;

  int checks = 0;
  int errors = 0;
  int trace_bad;
  int err_pulses;
  int err_pulses_s;

  // one clock: launch an operand set (optionally with a faulty adder answer),
  // present the adder result due this cycle, then update the model
  task automatic tick(input logic rst, input logic v, input logic [BW-1:0] a,
                      input logic [BW-1:0] b, input logic c, input logic [BW:0] fmask);
    item_t  cur, old;
    longint s;
    s = longint'(a) + longint'(b) + longint'(c);
    cur.v = v; cur.a = a; cur.b = b; cur.c = c;
    cur.exp = s[BW:0];
    cur.got = cur.exp ^ fmask;
    old = '0;
    if (hist.size() >= LAT) old = hist[hist.size() - LAT];
    else old.got = {1'($urandom), $urandom};
    RESET = rst; in_vld = v; A = a; B = b; cin = c;
    {cout, sum} = old.got;
    @(posedge CLK);
    #1;
    if (rst) begin
      mdl_chk = 0; mdl_errc = 0; mdl_chk_s = 0; mdl_errc_s = 0;
      mdl_err = 1'b0; mdl_fail = 1'b0; mdl_fexp = '0; mdl_fgot = '0;
      hist.delete();
    end else begin
      mdl_err = 1'b0;
      if (old.v) begin
        if (mdl_chk < MAX_M) mdl_chk++;
        if (mdl_chk_s < MAX_S) mdl_chk_s++;
        if (old.got != old.exp) begin
          mdl_err = 1'b1;
          if (mdl_errc < MAX_M) mdl_errc++;
          if (mdl_errc_s < MAX_S) mdl_errc_s++;
          if (!mdl_fail) begin
            mdl_fexp = old.exp;
            mdl_fgot = old.got;
          end
          mdl_fail = 1'b1;
        end
      end
      hist.push_back(cur);
      if (hist.size() > LAT) void'(hist.pop_front());
    end
    if (err !== mdl_err || fail !== mdl_fail || chk_cnt !== CW'(mdl_chk) ||
        err_cnt !== CW'(mdl_errc) || first_exp !== mdl_fexp || first_got !== mdl_fgot ||
        err_s !== mdl_err || fail_s !== mdl_fail || chk_cnt_s !== CW_S'(mdl_chk_s) ||
        err_cnt_s !== CW_S'(mdl_errc_s) || first_exp_s !== mdl_fexp || first_got_s !== mdl_fgot)
      trace_bad++;
    if (err === 1'b1) err_pulses++;
    if (err_s === 1'b1) err_pulses_s++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom, $urandom, 1'($urandom), '0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, $urandom, $urandom, 1'($urandom), '0);
    tick(1'b1, 1'b0, $urandom, $urandom, 1'($urandom), '0);
  endtask

  task automatic begin_test();
    trace_bad = 0; err_pulses = 0; err_pulses_s = 0;
  endtask

  task automatic test_reset();
    begin_test();
    do_reset();
    idle(10);
    checks++; if (chk_cnt !== '0) begin errors++; $display("FAIL reset_chk_cnt: got %0d expected 0", chk_cnt); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", fail); end
    checks++; if (first_exp !== '0 || first_got !== '0) begin errors++;
      $display("FAIL reset_first: got exp %h got %h expected 0/0", first_exp, first_got); end
    checks++; if (err_pulses !== 0) begin errors++; $display("FAIL reset_err_pulses: got %0d expected 0", err_pulses); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL reset_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  task automatic test_match_stream();
    logic [BW-1:0] av, bv;
    begin_test();
    do_reset();
    av = $urandom; bv = $urandom;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b1, av, bv, 1'($urandom), '0);
      av += 32'd30000; bv += 32'd50000;
    end
    idle(3);
    checks++; if (chk_cnt !== 16'd100) begin errors++; $display("FAIL stream_chk_cnt: got %0d expected 100", chk_cnt); end
    checks++; if (err_cnt !== '0 || fail !== 1'b0) begin errors++;
      $display("FAIL stream_err: got err_cnt %0d fail %b expected 0/0", err_cnt, fail); end
    checks++; if (err_pulses !== 0) begin errors++; $display("FAIL stream_err_pulses: got %0d expected 0", err_pulses); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL stream_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  task automatic test_carry_boundary();
    begin_test();
    do_reset();
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, '0);
    idle(3);
    checks++; if (err_pulses !== 0 || err_cnt !== '0 || chk_cnt !== 16'd1) begin errors++;
      $display("FAIL carry_ok: got pulses %0d err_cnt %0d chk_cnt %0d expected 0/0/1", err_pulses, err_cnt, chk_cnt); end
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 33'h1_0000_0000);
    idle(2);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL carry_early: err got %b expected 0", err); end
    idle(1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL carry_err: err got %b expected 1", err); end
    checks++; if (first_exp !== 33'h1_0000_0001) begin errors++;
      $display("FAIL carry_first_exp: got %h expected 100000001", first_exp); end
    checks++; if (first_got !== 33'h0_0000_0001) begin errors++;
      $display("FAIL carry_first_got: got %h expected 000000001", first_got); end
    idle(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL carry_pulse_width: err got %b expected 0", err); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL carry_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  task automatic test_first_capture();
    logic [BW-1:0] a, b;
    logic          c;
    logic [BW:0]   m, e10, g10;
    e10 = '0; g10 = '0;
    begin_test();
    do_reset();
    for (int i = 0; i < 25; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom);
      m = (i == 10 || i == 11 || i == 20) ? (33'($urandom) | 33'h1) : '0;
      if (i == 10) begin
        e10 = 33'(a) + 33'(b) + 33'(c);
        g10 = e10 ^ m;
      end
      tick(1'b0, 1'b1, a, b, c, m);
    end
    idle(3);
    checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL capture_err_cnt: got %0d expected 3", err_cnt); end
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL capture_fail: got %b expected 1", fail); end
    checks++; if (first_exp !== e10 || first_got !== g10) begin errors++;
      $display("FAIL capture_first: got %h/%h expected %h/%h", first_exp, first_got, e10, g10); end
    checks++; if (err_pulses !== 3) begin errors++; $display("FAIL capture_pulses: got %0d expected 3", err_pulses); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL capture_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  task automatic test_reset_midstream();
    begin_test();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 33'($urandom) | 33'h1);
    tick(1'b1, 1'b1, $urandom, $urandom, 1'($urandom), 33'h1);
    idle(6);
    checks++; if (err_pulses !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d expected 0", err_pulses); end
    checks++; if (chk_cnt !== '0 || err_cnt !== '0 || fail !== 1'b0) begin errors++;
      $display("FAIL midreset_cnt: got chk %0d err %0d fail %b expected 0/0/0", chk_cnt, err_cnt, fail); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL midreset_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  task automatic test_saturation();
    begin_test();
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 33'($urandom) | 33'h1);
    idle(3);
    checks++; if (err_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_err_cnt: got %0d expected 15", err_cnt_s); end
    checks++; if (chk_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_chk_cnt: got %0d expected 15", chk_cnt_s); end
    checks++; if (err_pulses_s !== 20) begin errors++; $display("FAIL sat_pulses: got %0d expected 20", err_pulses_s); end
    checks++; if (err_cnt !== 16'd20 || fail_s !== 1'b1) begin errors++;
      $display("FAIL sat_wide: got err_cnt %0d fail_s %b expected 20/1", err_cnt, fail_s); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL sat_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  task automatic test_back_to_back();
    begin_test();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 59) == 0), 1'($urandom), $urandom, $urandom, 1'($urandom),
           ($urandom_range(0, 7) == 0) ? (33'($urandom) | 33'h4) : '0);
    end
    idle(3);
    checks++; if (chk_cnt !== CW'(mdl_chk)) begin errors++; $display("FAIL b2b_chk_cnt: got %0d expected %0d", chk_cnt, mdl_chk); end
    checks++; if (err_cnt !== CW'(mdl_errc)) begin errors++; $display("FAIL b2b_err_cnt: got %0d expected %0d", err_cnt, mdl_errc); end
    checks++; if (first_exp !== mdl_fexp || first_got !== mdl_fgot) begin errors++;
      $display("FAIL b2b_first: got %h/%h expected %h/%h", first_exp, first_got, mdl_fexp, mdl_fgot); end
    checks++; if (trace_bad !== 0) begin errors++; $display("FAIL b2b_trace: %0d cycles differ from model, expected 0", trace_bad); end
  endtask

  initial begin
    test_reset();
    test_match_stream();
    test_carry_boundary();
    test_first_capture();
    test_reset_midstream();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ks_adder_checker.md
# ks_adder_checker

Synthesizable response checker for the pipelined Kogge-Stone N-bit adder. It captures each operand set driven into the adder and delays it through a valid-tagged shift line matching the adder's pipeline latency. It then compares the adder's `sum`/`cout` against a golden `A+B+cin` and keeps pass/fail statistics. It sits beside the adder in the bring-up/self-test harness, consuming the adder's output side.

## Interface
- `bw`, 32, operand width; operands indexed `[bw:1]`
- `LAT`, 3, adder pipeline latency in cycles; legal range 1..16
- `CW`, 16, width of the check and error counters

Ports:
- `CLK`  in  1  single clock, rising edge
- `RESET`  in  1  synchronous, active-high reset
- `in_vld`  in  1  operand set on `A`/`B`/`cin` is being launched into the adder this cycle
- `A`  in  bw  adder operand A, `[bw:1]`
- `B`  in  bw  adder operand B, `[bw:1]`
- `cin`  in  1  adder carry-in
- `sum`  in  bw  adder sum output, `[bw:1]`
- `cout`  in  1  adder carry-out
- `err`  out  1  one-cycle pulse: the compared result mismatched
- `fail`  out  1  sticky: at least one mismatch since reset
- `chk_cnt`  out  CW  number of compares performed, saturating
- `err_cnt`  out  CW  number of mismatches, saturating
- `first_exp`  out  bw+1  expected `{cout,sum}` of the first mismatch
- `first_got`  out  bw+1  observed `{cout,sum}` of the first mismatch

## Operation
- Delay line: `LAT` stages, each holding `{vld, A, B, cin}`. Stage 1 loads the inputs every cycle; stage k loads stage k-1. No stall and no backpressure.
- Golden: `exp = {1'b0,A_d} + {1'b0,B_d} + cin_d`, computed at (bw+1) bits from the stage-`LAT` contents. The MSB is the expected carry-out. Wrap-around is modular 2^(bw+1); there is no overflow flag.
- Compare: when stage-`LAT` `vld`=1, compare `exp` against `{cout,sum}`. When `vld`=0, no compare is made, no counter changes, and `err`=0.
- Mismatch handling:
  - `err`=1 for exactly that cycle's registered result.
  - `err_cnt` increments.
  - `fail` sets.
  - If `fail` was 0 before this mismatch, `first_exp`/`first_got` load the exp/got values; otherwise they hold.
- `chk_cnt` increments on every compare, pass or fail.
- Counters saturate at 2^CW-1 and never wrap.
- Simultaneous mismatch and saturation: `err` still pulses and `fail` still sets; `err_cnt` holds at max.
- Reset (synchronous, wins over all other activity, including mid-stream):
  - All stage `vld` bits clear, so in-flight operands are discarded and produce no compares.
  - `err`=0, `fail`=0, `chk_cnt`=0, `err_cnt`=0, `first_exp`=0, `first_got`=0.
  - Stage data bits may stay unreset because they are masked by `vld`.
- After reset, the first `LAT` cycles have no valid stages. Adder outputs during warm-up are ignored.

## Timing
- Operand launched with `in_vld`=1 at edge t reaches stage `LAT` after edge t+LAT-1. It is compared against `sum`/`cout` present during cycle t+LAT, i.e. the adder's result LAT cycles after launch.
- `err`, counters, `fail`, and the captured values update at edge t+LAT. They are visible in cycle t+LAT+1 (one register after compare).
- End-to-end: operand launch to `err` visible = `LAT`+1 cycles.
- Throughput: one compare per cycle, with back-to-back `in_vld` supported.
- All outputs are registered.
- `RESET` asserted at edge r: all outputs read reset values from cycle r+1. A `vld` launched in the same cycle as `RESET` is dropped.

## Test plan
- **Warm-up and reset values:** assert `RESET` for 2 cycles, then hold `in_vld`=0 for 10 cycles. Required: `chk_cnt`=0, `err_cnt`=0, `fail`=0, `err` never high, `first_exp`=0, `first_got`=0.
- **Matching stream:** bw=32, LAT=3, correct adder model. Stimulus: A steps by 30000 and B by 50000 per cycle, `in_vld`=1, 100 cycles. Required: `chk_cnt`=100 and `err_cnt`=0 three cycles after the last launch; `fail`=0.
- **Carry boundary:** A=32'hFFFFFFFF, B=1, cin=1, with the adder returning sum=1, cout=1. Required: no `err`. Then force the returned `cout`=0. Required: `err` pulses at launch+4, `first_exp`=33'h1_00000001, `first_got`=33'h0_00000001.
- **First-capture hold:** inject three mismatches at cycles 10, 11, and 20. Required: `err_cnt`=3 and `fail`=1. `first_exp`/`first_got` hold the cycle-10 values.
- **Reset mid-stream:** launch 3 valid sets, then assert `RESET` one cycle later with faulty adder outputs. Required: no `err` pulse and `chk_cnt`=0 after reset.
- **Saturation:** CW=4 with 20 consecutive mismatches. Required: `err_cnt`=15 and `chk_cnt`=15, with `err` still pulsing on all 20.
